enemy_fire_scheduler: RTL
=========================

Name: enemy_fire_scheduler

Overview:
- Schedules enemy return fire for the fleet. The playfield has one enemy bullet slot, and this block shares it between the front ship of each column.
- It enforces a cooldown between shots and picks the firing column round-robin.
- It launches the bullet from that ship's position and moves it down once per frame until the bullet hits something or leaves the screen.
- It sits between the per-column enemy ships and the VGA/collision logic.

Parameters:
num_cols_p, 8, number of enemy columns / requesters
bullet_delay_p, 5, cooldown between shots, in seconds
frames_per_sec_p, 60, frame_i pulses per second
bullet_step_p, 4, pixels the bullet moves down per frame
bullet_len_p, 10, bullet height in pixels
ship_width_p, 40, enemy ship width; bullet x = ship left + ship_width_p/2 - 2
screen_bot_p, 479, last visible row

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
frame_i  in  1  one-cycle pulse per rendered frame
start_i  in  1  btnC: enables firing
col_req_i  in  num_cols_p  bit c = column c has a living front ship
col_left_i  in  10*num_cols_p  packed left position of each column's front ship (column c at [10c+9:10c])
col_bot_i  in  10*num_cols_p  packed bottom position of each column's front ship
bullet_hit_i  in  1  collision logic reports the bullet hit the player or a shield
grant_o  out  num_cols_p  one-hot column that fired last (held while the bullet flies)
fire_o  out  1  one-cycle pulse when a bullet launches
bullet_active_o  out  1  bullet is on screen
bullet_left_o  out  10  bullet left x
bullet_top_o  out  10  bullet top y
bullet_bot_o  out  10  bullet_top_o + bullet_len_p - 1

Behaviour:
- One clock, clk_i. reset_i is asynchronous and active-high.
- Reset values: state=IDLE, all outputs 0, cooldown count 0, round-robin pointer 0 (column 0 has highest priority first).
- FSM states:
  - IDLE: wait for start_i = 1, then go to COOLDOWN with the count cleared.
  - COOLDOWN: count increments on frame_i. When count == bullet_delay_p*frames_per_sec_p - 1 and frame_i is high, go to SELECT. With defaults that is exactly 300 frames after entry.
  - SELECT: if col_req_i == 0, stay in SELECT with no timeout.
    - Otherwise, in one cycle: grant the first set bit at or after the pointer, wrapping.
    - Latch bullet_left = col_left[g] + ship_width_p/2 - 2 and bullet_top = col_bot[g] + 1.
    - Set the pointer to g+1 mod num_cols_p, pulse fire_o, go to FLYING.
  - FLYING: bullet_active_o = 1. On frame_i, bullet_top += bullet_step_p.
    - If bullet_hit_i, or bullet_top + bullet_step_p + bullet_len_p - 1 > screen_bot_p on a frame: go to COOLDOWN, clear active and count.
- Latency: fire_o asserts the cycle after entering SELECT with a nonzero request. Outputs are registered.
- Simultaneous bullet_hit_i and frame_i: the hit wins and the bullet does not move.
- Priority of exit conditions: hit, then off-screen.
- Width rules:
  - All position arithmetic is 10-bit unsigned.
  - The off-screen compare uses an 11-bit sum so it cannot wrap.
  - A launch position with col_bot >= screen_bot_p retires on the first frame.
- Requests deasserting during FLYING do not affect the bullet (the ship's death does not cancel its shot). grant_o is held.
- start_i outside IDLE is ignored.
- reset_i asserted mid-flight returns to IDLE immediately and clears the bullet.
- frame_i in IDLE or SELECT has no effect on the counters.

Decomposition:
- Shared package (enemy_pkg): the state enum {IDLE, COOLDOWN, SELECT, FLYING} and the screen constants (screen_bot, ship width). Other enemy blocks use the same package.
- Sub-module rr_arbiter #(width_p): combinational one-hot round-robin grant from a request vector and a pointer, plus a registered pointer update on an accept input. It is reusable for other shared resources.

Test Plan:
- Default parameters, start_i pulse, col_req_i=8'hFF → fire_o exactly 300 frames after start; grant_o=8'h01; bullet_left_o = col_left[0]+18.
- Overrides bullet_delay_p=1, frames_per_sec_p=4, all requests set, bullet left to fly off the bottom each time → grants in order 01,02,04,...,80,01; four frames between retirement and the next fire_o.
- col_req_i=8'b0010_0100, pointer at 3 → grant 8'h20. Drop col_req_i[5] mid-flight → bullet continues unchanged.
- col_bot=400, step 4, len 10 → bullet retires on the frame where top would exceed 470; bullet_active_o falls and no wrap to a small y occurs.
- bullet_hit_i and frame_i in the same cycle → bullet_top_o unchanged, active drops next cycle, back in COOLDOWN.
- col_req_i=0 at cooldown expiry → stays in SELECT with no fire_o. Setting one bit → fire_o next cycle. Asserting reset_i mid-flight → all outputs 0 asynchronously and state IDLE.

Source files
------------

// File: rtl/enemy_pkg.sv
// -----------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy-side blocks: screen geometry constants,
// the position width, and the fire-scheduler state enumeration.
// No ports (package).
// -----------------------------------------------------------------------------
package enemy_pkg;

    localparam int POS_W      = 10;   // all on-screen coordinates are 10-bit
    localparam int SCREEN_BOT = 479;  // last visible row
    localparam int SHIP_WIDTH = 40;   // enemy ship sprite width in pixels

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        SELECT   = 2'd2,
        FLYING   = 2'd3
    } enemy_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// One-hot round-robin arbiter. The grant is purely combinational from the
// request vector and the current pointer: the first set request at or after
// the pointer wins, wrapping past the top. When accept_i is high and some
// request is present, the pointer moves to one past the granted index.
//
// Ports:
//   clk_i        in   clock
//   reset_i      in   asynchronous active-high reset (pointer -> 0)
//   req_i        in   request vector, width_p bits
//   accept_i     in   consume the current grant and advance the pointer
//   grant_o      out  one-hot grant (all zero when req_i == 0)
//   grant_idx_o  out  binary index of the granted bit
//   any_o        out  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int width_p = 8,
    parameter int idx_w_p = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] req_i,
    input  logic               accept_i,
    output logic [width_p-1:0] grant_o,
    output logic [idx_w_p-1:0] grant_idx_o,
    output logic               any_o
);

    logic [idx_w_p-1:0] r_ptr;
    logic [width_p-1:0] w_mask;
    logic [width_p-1:0] w_hi;
    logic [width_p-1:0] w_grant_hi;
    logic [width_p-1:0] w_grant_lo;
    logic [width_p-1:0] w_grant;
    logic [idx_w_p-1:0] w_idx;
    logic               w_seen_hi;
    logic               w_seen_lo;

    // Requests at or above the pointer form the high-priority half; if none
    // of them is set, the lowest request overall wins (that is the wrap).
    for (genvar gi = 0; gi < width_p; gi++) begin : g_mask
        assign w_mask[gi] = (idx_w_p'(gi) >= r_ptr);
    end
    assign w_hi = req_i & w_mask;

    always_comb begin
        w_grant_hi = '0;
        w_grant_lo = '0;
        w_seen_hi  = 1'b0;
        w_seen_lo  = 1'b0;
        for (int i = 0; i < width_p; i++) begin
            if (w_hi[i] && !w_seen_hi) begin
                w_grant_hi[i] = 1'b1;
                w_seen_hi     = 1'b1;
            end
            if (req_i[i] && !w_seen_lo) begin
                w_grant_lo[i] = 1'b1;
                w_seen_lo     = 1'b1;
            end
        end
    end

    assign w_grant = (|w_hi) ? w_grant_hi : w_grant_lo;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < width_p; i++) begin
            if (w_grant[i]) begin
                w_idx = w_idx | idx_w_p'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else if (accept_i && (|req_i)) begin
            r_ptr <= (w_idx == idx_w_p'(width_p - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign grant_o     = w_grant;
    assign grant_idx_o = w_idx;
    assign any_o       = |req_i;

endmodule

// File: rtl/enemy_fire_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_fire_scheduler
// Shares the single enemy bullet slot among the front ships of each column.
// After start it waits a cooldown (counted in frames), picks a requesting
// column round-robin, launches the bullet under that ship and steps it down
// once per frame until the collision logic reports a hit or it would leave
// the bottom of the screen; then the cooldown starts again.
//
// Ports:
//   clk_i            in   system clock
//   reset_i          in   asynchronous active-high reset
//   frame_i          in   one-cycle pulse per rendered frame
//   start_i          in   enables firing (only looked at in IDLE)
//   col_req_i        in   bit c = column c has a living front ship
//   col_left_i       in   packed left x of each front ship, 10 bits per column
//   col_bot_i        in   packed bottom y of each front ship, 10 bits per column
//   bullet_hit_i     in   bullet hit the player or a shield
//   grant_o          out  one-hot column that fired last
//   fire_o           out  one-cycle pulse at launch
//   bullet_active_o  out  bullet is on screen
//   bullet_left_o    out  bullet left x
//   bullet_top_o     out  bullet top y
//   bullet_bot_o     out  bullet bottom y (top + bullet_len_p - 1)
// -----------------------------------------------------------------------------
module enemy_fire_scheduler
    import enemy_pkg::*;
#(
    parameter int num_cols_p       = 8,
    parameter int bullet_delay_p   = 5,
    parameter int frames_per_sec_p = 60,
    parameter int bullet_step_p    = 4,
    parameter int bullet_len_p     = 10,
    parameter int ship_width_p     = SHIP_WIDTH,
    parameter int screen_bot_p     = SCREEN_BOT
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       frame_i,
    input  logic                       start_i,
    input  logic [num_cols_p-1:0]      col_req_i,
    input  logic [POS_W*num_cols_p-1:0] col_left_i,
    input  logic [POS_W*num_cols_p-1:0] col_bot_i,
    input  logic                       bullet_hit_i,
    output logic [num_cols_p-1:0]      grant_o,
    output logic                       fire_o,
    output logic                       bullet_active_o,
    output logic [POS_W-1:0]           bullet_left_o,
    output logic [POS_W-1:0]           bullet_top_o,
    output logic [POS_W-1:0]           bullet_bot_o
);

    localparam int cd_total_lp = bullet_delay_p * frames_per_sec_p;
    localparam int cnt_w_lp    = (cd_total_lp > 1) ? $clog2(cd_total_lp) : 1;
    localparam int idx_w_lp    = (num_cols_p > 1) ? $clog2(num_cols_p) : 1;

    localparam logic [cnt_w_lp-1:0] cd_last_lp   = cnt_w_lp'(cd_total_lp - 1);
    localparam logic [POS_W-1:0]    x_offs_lp    = POS_W'(ship_width_p / 2 - 2);
    localparam logic [POS_W-1:0]    step_lp      = POS_W'(bullet_step_p);
    localparam logic [POS_W-1:0]    len_m1_lp    = POS_W'(bullet_len_p - 1);
    localparam logic [POS_W:0]      reach_lp     = (POS_W + 1)'(bullet_step_p + bullet_len_p - 1);
    localparam logic [POS_W:0]      screen_bot_w = (POS_W + 1)'(screen_bot_p);

    enemy_state_t          r_state;
    enemy_state_t          w_state_next;
    logic [cnt_w_lp-1:0]   r_count;
    logic [cnt_w_lp-1:0]   w_count_next;
    logic [num_cols_p-1:0] r_grant;
    logic [num_cols_p-1:0] w_grant_next;
    logic                  r_fire;
    logic                  w_fire_next;
    logic                  r_active;
    logic                  w_active_next;
    logic [POS_W-1:0]      r_left;
    logic [POS_W-1:0]      w_left_next;
    logic [POS_W-1:0]      r_top;
    logic [POS_W-1:0]      w_top_next;
    logic [POS_W-1:0]      r_bot;
    logic [POS_W-1:0]      w_bot_next;

    logic [POS_W-1:0]      w_col_left [num_cols_p];
    logic [POS_W-1:0]      w_col_bot  [num_cols_p];
    logic [num_cols_p-1:0] w_arb_grant;
    logic [idx_w_lp-1:0]   w_arb_idx;
    logic                  w_arb_any;
    logic                  w_accept;
    logic [POS_W-1:0]      w_launch_left;
    logic [POS_W-1:0]      w_launch_top;
    logic [POS_W-1:0]      w_step_top;
    logic                  w_offscreen;

    for (genvar gi = 0; gi < num_cols_p; gi++) begin : g_unpack
        assign w_col_left[gi] = col_left_i[POS_W*gi +: POS_W];
        assign w_col_bot[gi]  = col_bot_i[POS_W*gi +: POS_W];
    end

    // The pointer advances only when a shot actually launches.
    assign w_accept = (r_state == SELECT) && w_arb_any;

    rr_arbiter #(
        .width_p (num_cols_p),
        .idx_w_p (idx_w_lp)
    ) u_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (col_req_i),
        .accept_i    (w_accept),
        .grant_o     (w_arb_grant),
        .grant_idx_o (w_arb_idx),
        .any_o       (w_arb_any)
    );

    assign w_launch_left = w_col_left[w_arb_idx] + x_offs_lp;
    assign w_launch_top  = w_col_bot[w_arb_idx] + 10'd1;
    assign w_step_top    = r_top + step_lp;

    // Widened by one bit so a bullet near the bottom cannot wrap to a small y
    // and appear to still be on screen.
    assign w_offscreen = ({1'b0, r_top} + reach_lp) > screen_bot_w;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_grant  <= '0;
            r_fire   <= 1'b0;
            r_active <= 1'b0;
            r_left   <= '0;
            r_top    <= '0;
            r_bot    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_grant  <= w_grant_next;
            r_fire   <= w_fire_next;
            r_active <= w_active_next;
            r_left   <= w_left_next;
            r_top    <= w_top_next;
            r_bot    <= w_bot_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_grant_next  = r_grant;
        w_fire_next   = 1'b0;
        w_active_next = r_active;
        w_left_next   = r_left;
        w_top_next    = r_top;
        w_bot_next    = r_bot;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = COOLDOWN;
                    w_count_next = '0;
                end
            end

            COOLDOWN: begin
                if (frame_i) begin
                    if (r_count == cd_last_lp) begin
                        w_state_next = SELECT;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
            end

            SELECT: begin
                // With no living front ship the scheduler simply waits here.
                if (w_arb_any) begin
                    w_grant_next  = w_arb_grant;
                    w_fire_next   = 1'b1;
                    w_active_next = 1'b1;
                    w_left_next   = w_launch_left;
                    w_top_next    = w_launch_top;
                    w_bot_next    = w_launch_top + len_m1_lp;
                    w_state_next  = FLYING;
                end
            end

            FLYING: begin
                // A hit in the same cycle as a frame wins: the bullet is
                // retired where it was drawn, not one step further.
                if (bullet_hit_i || (frame_i && w_offscreen)) begin
                    w_active_next = 1'b0;
                    w_count_next  = '0;
                    w_state_next  = COOLDOWN;
                end else if (frame_i) begin
                    w_top_next = w_step_top;
                    w_bot_next = w_step_top + len_m1_lp;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign grant_o         = r_grant;
    assign fire_o          = r_fire;
    assign bullet_active_o = r_active;
    assign bullet_left_o   = r_left;
    assign bullet_top_o    = r_top;
    assign bullet_bot_o    = r_bot;

endmodule
